// File: rtl/dlsc_pcie_s6_outbound_read_alloc_if.sv
// Handshake bundle between the read allocator, the outbound read buffer and the TLP request builder.
interface dlsc_pcie_s6_outbound_read_alloc_if #(
  parameter int ADDR = 32,
  parameter int LEN  = 4,
  parameter int TAG  = 5,
  parameter int BUFA = 9
);
  logic              cmd_ar_ready;
  logic              cmd_ar_valid;
  logic [ADDR-3:0]   cmd_ar_addr;
  logic [LEN-1:0]    cmd_ar_len;

  logic              req_ready;
  logic              req_valid;
  logic [ADDR-3:0]   req_addr;
  logic [LEN-1:0]    req_len;
  logic [TAG-1:0]    req_tag;

  logic              alloc_init;
  logic              alloc_valid;
  logic [TAG:0]      alloc_tag;
  logic [BUFA:0]     alloc_bufa;
  logic              dealloc_tag;
  logic              dealloc_data;

  // allocator side
  modport slave (
    output cmd_ar_ready,
    input  cmd_ar_valid, cmd_ar_addr, cmd_ar_len,
    input  req_ready,
    output req_valid, req_addr, req_len, req_tag,
    output alloc_init, alloc_valid, alloc_tag, alloc_bufa,
    input  dealloc_tag, dealloc_data
  );

  // buffer / request builder side
  modport master (
    input  cmd_ar_ready,
    output cmd_ar_valid, cmd_ar_addr, cmd_ar_len,
    output req_ready,
    input  req_valid, req_addr, req_len, req_tag,
    input  alloc_init, alloc_valid, alloc_tag, alloc_bufa,
    output dealloc_tag, dealloc_data
  );
endinterface

// File: rtl/dlsc_pcie_s6_outbound_read_alloc.sv
// PCIe read tag / read-buffer space allocator for outbound AXI reads.
// Optional accounting checks: define DLSC_PCIE_S6_RD_ALLOC_CHECK_EN.
module dlsc_pcie_s6_outbound_read_alloc #(
  parameter int ADDR = 32,
  parameter int LEN  = 4,
  parameter int TAG  = 5,
  parameter int BUFA = 9
) (
  input  logic                                  clk,
  input  logic                                  rst,
  dlsc_pcie_s6_outbound_read_alloc_if.slave     bus,
  input  logic [TAG-1:0]                        cfg_tag_max,
  output logic                                  alloc_busy,
  output logic                                  alloc_err
);

  if (BUFA < LEN) begin : g_param_chk
    $error("dlsc_pcie_s6_outbound_read_alloc: BUFA (%0d) must be >= LEN (%0d)", BUFA, LEN);
  end

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_ALLOC = 2'd2;
  localparam logic [1:0] ST_REQ   = 2'd3;

  localparam logic [BUFA:0] BUF_SIZE = {1'b1, {BUFA{1'b0}}};
  localparam logic [BUFA:0] ONE_B    = {{BUFA{1'b0}}, 1'b1};
  localparam logic [TAG:0]  ONE_T    = {{TAG{1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic             init_q;
  logic [ADDR-3:0]  addr_q;
  logic [LEN-1:0]   len_q;
  logic [TAG-1:0]   tag_q;
  logic [TAG:0]     alloc_tag_q;
  logic [BUFA:0]    alloc_bufa_q;
  logic [TAG:0]     tag_out_q, tag_out_d;
  logic [BUFA:0]    data_free_q, data_free_d;

  logic [BUFA:0]    cmd_words, len_words;
  logic             tag_ok, data_ok, rdy, accept, do_alloc;

  assign cmd_words = {{(BUFA+1-LEN){1'b0}}, bus.cmd_ar_len} + ONE_B;
  assign len_words = {{(BUFA+1-LEN){1'b0}}, len_q} + ONE_B;
  assign tag_ok    = tag_out_q <= {1'b0, cfg_tag_max};
  assign data_ok   = data_free_q >= cmd_words;
  assign rdy       = (state_q == ST_IDLE) && tag_ok && data_ok;
  assign accept    = rdy && bus.cmd_ar_valid;
  assign do_alloc  = (state_q == ST_ALLOC);

  assign bus.cmd_ar_ready = rdy;
  assign bus.req_valid    = (state_q == ST_REQ);
  assign bus.req_addr     = addr_q;
  assign bus.req_len      = len_q;
  assign bus.req_tag      = tag_q;
  assign bus.alloc_init   = init_q;
  assign bus.alloc_valid  = do_alloc;
  assign bus.alloc_tag    = alloc_tag_q;
  assign bus.alloc_bufa   = alloc_bufa_q;

  // INIT is not reported as busy so that busy reads 0 straight out of reset
  assign alloc_busy = (tag_out_q != '0) || (data_free_q != BUF_SIZE) ||
                      (state_q == ST_ALLOC) || (state_q == ST_REQ);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_q) state_d = ST_IDLE;
      ST_IDLE:  if (accept) state_d = ST_ALLOC;
      ST_ALLOC: state_d = ST_REQ;
      ST_REQ:   if (bus.req_ready) state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

`ifdef DLSC_PCIE_S6_RD_ALLOC_CHECK_EN
  logic err_q, err_d;
  assign alloc_err = err_q;

  // an underflow/overflow is only real when the concurrent alloc does not cancel it
  always_comb begin
    err_d       = err_q;
    tag_out_d   = tag_out_q;
    data_free_d = data_free_q;
    if (do_alloc) begin
      tag_out_d   = tag_out_d + ONE_T;
      data_free_d = data_free_d - len_words;
    end
    if (bus.dealloc_tag) begin
      if (tag_out_q == '0 && !do_alloc) err_d = 1'b1;
      else                              tag_out_d = tag_out_d - ONE_T;
    end
    if (bus.dealloc_data) begin
      if (data_free_q == BUF_SIZE && !do_alloc) err_d = 1'b1;
      else                                      data_free_d = data_free_d + ONE_B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign alloc_err = 1'b0;

  always_comb begin
    tag_out_d   = tag_out_q;
    data_free_d = data_free_q;
    if (do_alloc) begin
      tag_out_d   = tag_out_d + ONE_T;
      data_free_d = data_free_d - len_words;
    end
    if (bus.dealloc_tag)  tag_out_d   = tag_out_d - ONE_T;
    if (bus.dealloc_data) data_free_d = data_free_d + ONE_B;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_q       <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      tag_q        <= '0;
      alloc_tag_q  <= '0;
      alloc_bufa_q <= '0;
      tag_out_q    <= '0;
      data_free_q  <= BUF_SIZE;
    end else begin
      state_q     <= state_d;
      tag_out_q   <= tag_out_d;
      data_free_q <= data_free_d;
      init_q      <= (state_q == ST_INIT) && !init_q;
      if (accept) begin
        addr_q <= bus.cmd_ar_addr;
        len_q  <= bus.cmd_ar_len;
      end
      // pointers advance after the alloc_valid cycle so the buffer writes the old entry
      if (do_alloc) begin
        tag_q        <= alloc_tag_q[TAG-1:0];
        alloc_tag_q  <= alloc_tag_q + ONE_T;
        alloc_bufa_q <= alloc_bufa_q + len_words;
      end
    end
  end

endmodule
